// File: rtl/load_align_unit.sv
// load_align_unit: MEM-stage load path with alignment check, memory handshake, extraction, timeout; LOAD_ALIGN_LWLR_EN enables LWL/LWR merge (DATA_W=32 only)
module load_align_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_loadsel,
  input  logic [DATA_W-1:0] req_rt,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_exc
);
  localparam int LW = $clog2(DATA_W / 8);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, HOLD} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0] sel_q;
  logic [DATA_W-1:0] rt_q, sh, ext;
  logic [CW-1:0] cnt;
  logic mis, timed_out;
  logic [1:0] k;
  logic [31:0] lwl, lwr;
  // 64-bit-only codes (5/6) are reserved on a 32-bit datapath and so never fault
  assign mis = ((req_loadsel == 4'd1 || req_loadsel == 4'd2) && req_addr[0]) ||
               ((req_loadsel == 4'd0 || (DATA_W == 64 && req_loadsel == 4'd5)) && |req_addr[1:0]) ||
               (DATA_W == 64 && req_loadsel == 4'd6 && |req_addr[2:0]);
  assign timed_out = TIMEOUT != 0 && cnt == TLIM;
  assign k = addr_q[1:0];
  assign sh = mem_rdata >> {addr_q[LW-1:0], 3'b000};
  assign req_ready = state == IDLE;
  assign mem_req_valid = state == ISSUE;
  assign out_valid = state == HOLD;
  assign mem_addr = {addr_q[ADDR_W-1:LW], LW'(0)};
`ifdef LOAD_ALIGN_LWLR_EN
  assign lwl = (mem_rdata[31:0] << {~k, 3'b000}) | (rt_q[31:0] & (32'hFFFF_FFFF >> {({1'b0, k} + 3'd1), 3'b000}));
  assign lwr = (mem_rdata[31:0] >> {k, 3'b000}) | (rt_q[31:0] & ~(32'hFFFF_FFFF >> {k, 3'b000}));
`else
  logic unused_lwlr;
  assign lwl = '0;
  assign lwr = '0;
  assign unused_lwlr = ^{rt_q, k, lwl, lwr};
`endif
  // extract the addressed field and extend it per load code
  always_comb begin
    ext = '0;
    case (sel_q)
      4'd0: ext = DATA_W'($signed(sh[31:0]));
      4'd1: ext = DATA_W'($signed(sh[15:0]));
      4'd2: ext = DATA_W'(sh[15:0]);
      4'd3: ext = DATA_W'($signed(sh[7:0]));
      4'd4: ext = DATA_W'(sh[7:0]);
      4'd5: ext = DATA_W == 64 ? DATA_W'(sh[31:0]) : '0;
      4'd6: ext = DATA_W == 64 ? mem_rdata : '0;
`ifdef LOAD_ALIGN_LWLR_EN
      4'd7: ext = DATA_W'(lwl);
      4'd8: ext = DATA_W'(lwr);
`endif
      default: ext = '0;
    endcase
  end
  // next-state logic
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = req_valid ? (mis ? HOLD : ISSUE) : IDLE;
      ISSUE:    next = mem_req_ready ? WAIT_RSP : ISSUE;
      WAIT_RSP: next = (mem_rsp_valid || timed_out) ? HOLD : WAIT_RSP;
      default:  next = out_ready ? IDLE : HOLD;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // request latch, response timer and registered result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      sel_q <= '0;
      rt_q <= '0;
      cnt <= '0;
      out_data <= '0;
      out_exc <= 2'b00;
    end else begin
      cnt <= state != WAIT_RSP ? '0 : (cnt == '1 ? cnt : cnt + 1'b1);
      if (state == IDLE && req_valid) begin
        addr_q <= req_addr;
        sel_q <= req_loadsel;
        rt_q <= req_rt;
        out_data <= '0;
        out_exc <= mis ? 2'b01 : 2'b00;
      end
      if (state == WAIT_RSP && mem_rsp_valid) begin
        out_data <= ext;
        out_exc <= 2'b00;
      end else if (state == WAIT_RSP && timed_out) begin
        out_data <= '0;
        out_exc <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: scoreboard bench for load_align_unit (32-bit, TIMEOUT=8)
module tb_load_align_unit;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_ready;
  logic [31:0] req_addr = 0;
  logic [3:0] req_loadsel = 0;
  logic [31:0] req_rt = 0;
  logic mem_req_valid, mem_req_ready = 0;
  logic [31:0] mem_addr;
  logic mem_rsp_valid = 0;
  logic [31:0] mem_rdata = 0;
  logic out_valid, out_ready = 0;
  logic [31:0] out_data;
  logic [1:0] out_exc;
  int checks = 0, errors = 0;
  logic [33:0] q[$];
  load_align_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_loadsel(req_loadsel), .req_rt(req_rt),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [33:0] model(input logic [31:0] a, input logic [3:0] s, input logic [31:0] rt, input logic [31:0] rd);
    int kk;
    logic [7:0] b;
    logic [15:0] h;
    logic [31:0] r;
    kk = int'(a[1:0]);
    b = rd[8*kk +: 8];
    h = kk < 3 ? rd[8*kk +: 16] : 16'h0;
    r = 32'h0;
    case (s)
      4'd0: return kk != 0 ? {2'b01, 32'h0} : {2'b00, rd};
      4'd1: return a[0] ? {2'b01, 32'h0} : {2'b00, {16{h[15]}}, h};
      4'd2: return a[0] ? {2'b01, 32'h0} : {2'b00, 16'h0, h};
      4'd3: return {2'b00, {24{b[7]}}, b};
      4'd4: return {2'b00, 24'h0, b};
`ifdef LOAD_ALIGN_LWLR_EN
      4'd7: begin
        for (int i = 0; i < 4; i++) r[8*i +: 8] = i >= 3 - kk ? rd[8*(i-3+kk) +: 8] : rt[8*i +: 8];
        return {2'b00, r};
      end
      4'd8: begin
        for (int i = 0; i < 4; i++) r[8*i +: 8] = i <= 3 - kk ? rd[8*(i+kk) +: 8] : rt[8*i +: 8];
        return {2'b00, r};
      end
`endif
      default: return {2'b00, r};
    endcase
  endfunction
  task automatic do_load(input logic [31:0] a, input logic [3:0] s, input logic [31:0] rt, input logic [31:0] rd, input int hold);
    logic [33:0] e;
    e = model(a, s, rt, rd);
    q.push_back(e);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_addr = a; req_loadsel = s; req_rt = rt;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    if (e[33:32] == 2'b01) begin
      chk("no_mem_req", mem_req_valid, 0);
    end else begin
      chk("mem_req_valid", mem_req_valid, 1);
      chk("mem_addr", mem_addr, {a[31:2], 2'b00});
      mem_req_ready = 1;
      @(negedge clk);
      mem_req_ready = 0;
      chk("early_valid", out_valid, 0);
      mem_rsp_valid = 1; mem_rdata = rd;
      @(negedge clk);
      mem_rsp_valid = 0; mem_rdata = 32'h0;
    end
    chk("out_valid", out_valid, 1);
    if (q.size() == 0) chk("queue_empty", 1, 0);
    else begin
      e = q.pop_front();
      for (int i = 0; i <= hold; i++) begin
        chk("out_data", out_data, e[31:0]);
        chk("out_exc", out_exc, e[33:32]);
        chk("req_ready_hold", req_ready, 0);
        if (i < hold) @(negedge clk);
      end
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("out_valid_drop", out_valid, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [3:0] sels [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_req", mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_exc", out_exc, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 0;
    do_load(32'h1002, 4'd1, 32'h0, 32'h8899AABB, 0);
    do_load(32'h1001, 4'd4, 32'h0, 32'h8899AABB, 4);
    do_load(32'h1001, 4'd1, 32'h0, 32'h8899AABB, 0);
    do_load(32'h1002, 4'd0, 32'h0, 32'h8899AABB, 1);
    do_load(32'h1004, 4'd0, 32'h0, 32'hCAFEF00D, 0);
    do_load(32'h1003, 4'd3, 32'h0, 32'h80112233, 0);
    do_load(32'h1000, 4'd3, 32'h0, 32'h0000007F, 0);
    do_load(32'h1000, 4'd2, 32'h0, 32'h1234F00D, 0);
    do_load(32'h1001, 4'd6, 32'h0, 32'h12345678, 0);
    do_load(32'h1000, 4'd9, 32'h0, 32'h12345678, 0);
    do_load(32'h1001, 4'd7, 32'h11223344, 32'h8899AABB, 0);
    do_load(32'h1001, 4'd8, 32'h11223344, 32'h8899AABB, 0);
    // timeout: no response ever arrives
    q.push_back({2'b10, 32'h0});
    @(negedge clk);
    req_valid = 1; req_addr = 32'h3000; req_loadsel = 4'd0;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    chk("to_mem_req", mem_req_valid, 1);
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("to_not_yet", out_valid, 0);
    end
    @(negedge clk);
    chk("to_valid", out_valid, 1);
    if (q.size() == 0) chk("queue_empty", 1, 0);
    else begin
      logic [33:0] e;
      e = q.pop_front();
      chk("to_exc", out_exc, e[33:32]);
      chk("to_data", out_data, e[31:0]);
    end
    mem_rsp_valid = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_rsp_valid = 0;
    chk("stray_hold_data", out_data, 0);
    chk("stray_hold_exc", out_exc, 2'b10);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    mem_rsp_valid = 1;
    @(negedge clk);
    mem_rsp_valid = 0;
    chk("stray_idle_valid", out_valid, 0);
    chk("stray_idle_ready", req_ready, 1);
    // reset in the middle of WAIT_RSP
    @(negedge clk);
    req_valid = 1; req_addr = 32'h2000; req_loadsel = 4'd0;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    #2 reset = 1;
    #1;
    chk("ar_req_ready", req_ready, 1);
    chk("ar_mem_req", mem_req_valid, 0);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_mem_addr", mem_addr, 0);
    chk("ar_out_exc", out_exc, 0);
    @(negedge clk);
    reset = 0;
    mem_rsp_valid = 1; mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_rsp_valid = 0;
    chk("late_rsp_dropped", out_valid, 0);
    do_load(32'h2000, 4'd0, 32'h0, 32'hDEADBEEF, 0);
    for (int n = 0; n < 24; n++)
      do_load(32'h1000 + $urandom_range(0, 15), sels[$urandom_range(0, 9)], $urandom, $urandom, $urandom_range(0, 2));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
